// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation encoding, pipeline payloads.
package rv32i_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        logic    jump;
        logic    illegal;
        alu_op_e alu_ctrl;
    } ctrl_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101); callers decide when it applies
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 integer register file: two async read ports with writeback bypass, one sync write port.
module register_file
    import rv32i_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_active;

    assign wr_active = wb_en && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // x0 is hardwired to zero; a pending writeback is forwarded to a matching reader
    assign rs1_data = (rs1_addr == '0)                   ? '0      :
                      (wr_active && (wb_rd == rs1_addr)) ? wb_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0)                   ? '0      :
                      (wr_active && (wb_rd == rs2_addr)) ? wb_data : regs[rs2_addr];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, control decode, immediate generation, register read.
module decode_stage #(
    parameter logic [31:0] NOP_INSN = rv32i_pkg::NOP_INSN
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall,
    input  logic                                  flush,
    input  logic [rv32i_pkg::XLEN-1:0]            pc_in,
    input  logic [rv32i_pkg::XLEN-1:0]            instruction_in,
    input  logic                                  wb_en,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]      wb_rd,
    input  logic [rv32i_pkg::XLEN-1:0]            wb_data,
    output logic [rv32i_pkg::XLEN-1:0]            pc_out,
    output logic                                  valid_out,
    output logic [rv32i_pkg::REG_ADDR_W-1:0]      rs1,
    output logic [rv32i_pkg::REG_ADDR_W-1:0]      rs2,
    output logic [rv32i_pkg::REG_ADDR_W-1:0]      rd,
    output logic [rv32i_pkg::XLEN-1:0]            rs1_data,
    output logic [rv32i_pkg::XLEN-1:0]            rs2_data,
    output logic [rv32i_pkg::XLEN-1:0]            imm,
    output logic                                  reg_write,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic                                  mem_to_reg,
    output logic                                  alu_src,
    output logic                                  branch,
    output logic                                  jump,
    output logic                                  illegal,
    output logic [3:0]                            alu_ctrl
);

    import rv32i_pkg::*;

    if_id_t          if_id_q;
    ctrl_t           dec;
    imm_sel_e        imm_sel;
    logic [XLEN-1:0] ins;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    // IF/ID register: reset/flush insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_id_q <= '{pc: '0, instr: NOP_INSN, valid: 1'b0};
        end else if (!stall) begin
            if_id_q <= '{pc: pc_in, instr: instruction_in, valid: 1'b1};
        end
    end

    assign ins    = if_id_q.instr;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];
    assign rd     = ins[11:7];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];

    always_comb begin : decode
        dec     = '0;
        imm_sel = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
                imm_sel       = IMM_U;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_U;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_J;
            end
            OPC_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_I;
                dec.illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_sel      = IMM_B;
                dec.illegal  = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                imm_sel        = IMM_I;
                dec.illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_S;
                dec.illegal   = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_I;
                dec.alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                dec.illegal   = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                                ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec.alu_ctrl = alu_from_funct3(funct3, 1'b0);
                end else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    dec.alu_ctrl = alu_from_funct3(funct3, 1'b1);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                dec = '0;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        // an illegal word carries no side effects and no immediate
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            imm_sel     = IMM_NONE;
        end
        if (rd == '0) begin
            dec.reg_write = 1'b0;
        end
        if (!if_id_q.valid) begin
            dec     = '0;
            imm_sel = IMM_NONE;
        end
    end

    always_comb begin : imm_gen
        imm = '0;
        case (imm_sel)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    assign pc_out     = if_id_q.pc;
    assign valid_out  = if_id_q.valid;
    assign reg_write  = dec.reg_write;
    assign mem_read   = dec.mem_read;
    assign mem_write  = dec.mem_write;
    assign mem_to_reg = dec.mem_to_reg;
    assign alu_src    = dec.alu_src;
    assign branch     = dec.branch;
    assign jump       = dec.jump;
    assign illegal    = dec.illegal;
    assign alu_ctrl   = dec.alu_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;

    import rv32i_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] pc_in, instruction_in;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, illegal;
    logic [3:0]  alu_ctrl;

    always #5 clk = ~clk;

    decode_stage #(.NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_out(pc_out), .valid_out(valid_out),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch), .jump(jump),
        .illegal(illegal), .alu_ctrl(alu_ctrl)
    );

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    logic [31:0] m_regs [32];

    typedef struct packed {
        logic [11:0] ctrl;  // {rw, mr, mw, m2r, as, br, j, ill, alu[3:0]}
        logic [31:0] imm;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_decode(input logic [31:0] w, input logic v);
        exp_t        e;
        logic [6:0]  op = w[6:0];
        logic [2:0]  f3 = w[14:12];
        logic [6:0]  f7 = w[31:25];
        logic        rw = 0, mr = 0, mw = 0, m2r = 0, as = 0, br = 0, j = 0, ill = 0;
        logic [3:0]  alu = 4'(ALU_ADD);
        logic [31:0] im = 0;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [3:0]  f3_alu [8];
        f3_alu = '{4'(ALU_ADD), 4'(ALU_SLL), 4'(ALU_SLT), 4'(ALU_SLTU),
                   4'(ALU_XOR), 4'(ALU_SRL), 4'(ALU_OR), 4'(ALU_AND)};
        // immediates assembled arithmetically from the I-type sign-extended field
        imm_i = 32'($signed(w) >>> 20);
        imm_s = (imm_i & ~32'h1F) | 32'(w[11:7]);
        imm_b = (imm_s & ~32'h801) | (32'(w[7]) << 11);
        imm_u = w & 32'hFFFF_F000;
        imm_j = (imm_i & 32'hFFF0_07FE) | (w & 32'h000F_F000) | (32'(w[20]) << 11);
        case (op)
            7'h37: begin rw = 1; as = 1; alu = 4'(ALU_PASSB); im = imm_u; end
            7'h17: begin rw = 1; as = 1; im = imm_u; end
            7'h6F: begin rw = 1; j = 1; as = 1; im = imm_j; end
            7'h67: if (f3 == 0) begin rw = 1; j = 1; as = 1; im = imm_i; end else ill = 1;
            7'h63: if (f3 inside {0, 1, 4, 5, 6, 7}) begin br = 1; alu = 4'(ALU_SUB); im = imm_b; end
                   else ill = 1;
            7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin mr = 1; m2r = 1; rw = 1; as = 1; im = imm_i; end
                   else ill = 1;
            7'h23: if (f3 inside {0, 1, 2}) begin mw = 1; as = 1; im = imm_s; end else ill = 1;
            7'h13: begin
                if ((f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}))) ill = 1;
                else begin
                    rw = 1; as = 1; im = imm_i;
                    alu = (f3 == 5 && f7 == 7'h20) ? 4'(ALU_SRA) : f3_alu[f3];
                end
            end
            7'h33: begin
                if (f7 == 0) alu = f3_alu[f3];
                else if (f7 == 7'h20 && f3 == 0) alu = 4'(ALU_SUB);
                else if (f7 == 7'h20 && f3 == 5) alu = 4'(ALU_SRA);
                else ill = 1;
                rw = !ill;
            end
            7'h0F, 7'h73: begin end
            default: ill = 1;
        endcase
        if (ill) begin
            {rw, mr, mw, m2r, as, br, j} = '0;
            alu = 4'(ALU_ADD);
            im  = 0;
        end
        if (w[11:7] == 0) rw = 0;
        if (!v) begin
            {rw, mr, mw, m2r, as, br, j, ill} = '0;
            alu = 4'(ALU_ADD);
            im  = 0;
        end
        e.ctrl = {rw, mr, mw, m2r, as, br, j, ill, alu};
        e.imm  = im;
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic model_update();
        if (rst) begin
            m_pc = 0; m_instr = NOP; m_valid = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
        end else begin
            if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
            if (flush) begin
                m_pc = 0; m_instr = NOP; m_valid = 0;
            end else if (!stall) begin
                m_pc = pc_in; m_instr = instruction_in; m_valid = 1;
            end
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = model_decode(m_instr, m_valid);
        check_eq("pc_out", pc_out, m_pc);
        check_eq("valid_out", 32'(valid_out), 32'(m_valid));
        check_eq("rs1", 32'(rs1), 32'(m_instr[19:15]));
        check_eq("rs2", 32'(rs2), 32'(m_instr[24:20]));
        check_eq("rd", 32'(rd), 32'(m_instr[11:7]));
        check_eq("rs1_data", rs1_data, model_read(m_instr[19:15]));
        check_eq("rs2_data", rs2_data, model_read(m_instr[24:20]));
        check_eq("imm", imm, e.imm);
        check_eq("ctrl", 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src,
                              branch, jump, illegal, alu_ctrl}), 32'(e.ctrl));
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        rst = r; stall = s; flush = f; pc_in = pc; instruction_in = ins;
        wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    // drive, then sample at the falling edge
    task automatic apply(input logic r, input logic s, input logic f,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        drive(r, s, f, pc, ins, we, wr, wd);
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [31:0] side_fx();
        return 32'({reg_write, mem_read, mem_write, branch, jump});
    endfunction

    initial begin
        logic [6:0]  ops [11];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // post-reset outputs; addi x1,x0,5 presented at pc 0x4
        apply(0, 0, 0, 32'h4, 32'h0050_0093, 0, 0, 0);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        check_eq("rst_ctrl", 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src,
                                  branch, jump, illegal, alu_ctrl}), 32'h0);
        check_eq("rst_imm", imm, 32'h0);
        check_eq("rst_rs1_data", rs1_data, 32'h0);
        tick();

        // addi decoded one cycle later; add x2,x1,x1 presented
        apply(0, 0, 0, 32'h8, 32'h0010_8133, 0, 0, 0);
        check_eq("addi_rd", 32'(rd), 32'h1);
        check_eq("addi_imm", imm, 32'h5);
        check_eq("addi_alu_src", 32'(alu_src), 32'h1);
        check_eq("addi_reg_write", 32'(reg_write), 32'h1);
        check_eq("addi_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        check_eq("addi_valid", 32'(valid_out), 32'h1);
        check_eq("addi_pc", pc_out, 32'h4);
        tick();

        // bypass while add x2,x1,x1 decodes
        apply(0, 0, 0, 32'hC, 32'h0000_01B3, 1, 5'd1, 32'hDEAD_BEEF);
        check_eq("bypass_rs1", rs1_data, 32'hDEAD_BEEF);
        check_eq("bypass_rs2", rs2_data, 32'hDEAD_BEEF);
        tick();

        // write to x0 attempted while add x3,x0,x0 decodes
        apply(0, 0, 0, 32'h10, 32'h0010_8133, 1, 5'd0, 32'h0000_1234);
        check_eq("x0_during_write", rs1_data, 32'h0);
        tick();

        apply(0, 0, 0, 32'h14, 32'hFE00_0CE3, 0, 0, 0);
        check_eq("x1_after_write", rs1_data, 32'hDEAD_BEEF);
        tick();

        apply(0, 0, 0, 32'h18, 32'h0010_00EF, 0, 0, 0);
        check_eq("x0_after_write", rs1_data, 32'h0);
        check_eq("beq_imm", imm, 32'hFFFF_FFF8);
        check_eq("beq_branch", 32'(branch), 32'h1);
        check_eq("beq_reg_write", 32'(reg_write), 32'h0);
        tick();

        apply(0, 0, 0, 32'h1C, 32'h0050_0093, 0, 0, 0);
        check_eq("jal_imm", imm, 32'h0000_0800);
        check_eq("jal_jump", 32'(jump), 32'h1);
        tick();

        // stall with a new instruction waiting at the input
        for (int k = 0; k < 3; k++) begin
            apply(0, (k < 2), 0, 32'h20, 32'h1234_50B7, 0, 0, 0);
            check_eq("stall_pc", pc_out, 32'h1C);
            check_eq("stall_imm", imm, 32'h5);
            check_eq("stall_rd", 32'(rd), 32'h1);
            if (k < 2) tick();
        end
        drive(0, 1, 1, 32'h20, 32'h1234_50B7, 0, 0, 0);
        tick();
        apply(0, 0, 0, 32'h24, 32'h0000_00FF, 0, 0, 0);
        check_eq("flush_valid", 32'(valid_out), 32'h0);
        check_eq("flush_ctrl", 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src,
                                    branch, jump, illegal, alu_ctrl}), 32'h0);
        tick();

        apply(0, 0, 0, 32'h28, 32'h4020_9133, 0, 0, 0);
        check_eq("bad_opcode_illegal", 32'(illegal), 32'h1);
        check_eq("bad_opcode_fx", side_fx(), 32'h0);
        tick();

        apply(0, 0, 0, 32'h2C, NOP, 0, 0, 0);
        check_eq("bad_sub_illegal", 32'(illegal), 32'h1);
        check_eq("bad_sub_fx", side_fx(), 32'h0);
        tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            w = $urandom();
            if ($urandom_range(0, 9) != 0) begin
                w[6:0] = ops[$urandom_range(0, 10)];
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), {$urandom()} & 32'hFFFF_FFFC, w,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter NOP_INSN, default 32'h0000_0013, meaning the instruction word loaded on reset or flush (addi x0,x0,0).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, hold the IF/ID register contents.
REQ-005 The block SHALL have port flush, input, 1, replace the IF/ID contents with a bubble (taken branch/jump).
REQ-006 The block SHALL have port pc_in, input, 32, PC from fetch.
REQ-007 The block SHALL have port instruction_in, input, 32, instruction word from fetch.
REQ-008 The block SHALL have ports wb_en (input, 1), wb_rd (input, 5) and wb_data (input, 32), the writeback port.
REQ-009 The block SHALL have ports pc_out (output, 32) and valid_out (output, 1), the PC and validity of the decoded instruction.
REQ-010 The block SHALL have ports rs1 (output, 5), rs2 (output, 5) and rd (output, 5), the register indices.
REQ-011 The block SHALL have ports rs1_data (output, 32), rs2_data (output, 32) and imm (output, 32), the operand values and the sign-extended immediate.
REQ-012 The block SHALL have ports reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump and illegal (output, 1 each), and alu_ctrl (output, 4).

Function
REQ-013 The IF/ID register SHALL capture pc_in, instruction_in and valid=1 at each edge unless stall or flush is high.
REQ-014 When flush is high, the IF/ID register SHALL load pc=0, instr=NOP_INSN and valid=0; flush SHALL take priority over stall.
REQ-015 When stall is high and flush is low, the IF/ID register SHALL hold all of its fields unchanged.
REQ-016 All outputs SHALL be combinational from the IF/ID register and the register file, giving 1 cycle of latency from fetch inputs to decoded outputs.
REQ-017 The register file SHALL be 32x32 with two asynchronous read ports and one synchronous write port; it SHALL write wb_data to wb_rd on an edge when wb_en=1 and wb_rd!=0.
REQ-018 Register x0 SHALL read as 0 at all times; a write to x0 SHALL be discarded.
REQ-019 Same-cycle write/read bypass: if wb_en=1, wb_rd!=0 and wb_rd equals rs1 or rs2, the matching rsX_data SHALL equal wb_data in that cycle.
REQ-020 Writeback SHALL proceed regardless of stall or flush.
REQ-021 Immediates SHALL be formed per RV32I I, S, B, U and J formats, sign-extended from instr[31]; B and J immediates SHALL have bit0=0; U immediates SHALL have bits[11:0]=0; R-type immediates SHALL be 0.
REQ-022 The block SHALL decode the opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (as NOP) and SYSTEM (as NOP).
REQ-023 alu_ctrl SHALL encode ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and PASSB (LUI), selected from funct3 and funct7[5]; funct7[5] SHALL select SUB for OP only and SRA for shifts only.
REQ-024 Any unsupported opcode, or an invalid funct3/funct7 combination, SHALL assert illegal=1 and force all side-effect controls (reg_write, mem_read, mem_write, branch, jump) to 0.
REQ-025 When valid_out=0, all side-effect controls SHALL be 0.
REQ-026 reg_write SHALL be 0 whenever rd==0.

Reset
REQ-027 While rst=1 at an edge, the IF/ID register SHALL load pc=0, instr=NOP_INSN and valid=0, and registers x1..x31 SHALL be cleared to 0.
REQ-028 rst SHALL take priority over flush, stall and writeback.
REQ-029 After reset, outputs SHALL be pc_out=0, valid_out=0, all controls 0, imm=0 and rs*_data=0.

Structure
REQ-030 Opcode constants, the alu_ctrl encoding and NOP_INSN SHALL reside in a shared package, rv32i_pkg, used by the execute stage as well.
REQ-031 The register file SHALL be a separate sub-module named register_file; IF/ID, decode and immediate generation SHALL stay in decode_stage.

Verification
REQ-032 Test: reset, then present instr 0x00500093 (addi x1,x0,5) at pc 0x4 -> next cycle rd=1, imm=5, alu_src=1, reg_write=1, alu_ctrl=ADD, valid_out=1, pc_out=0x4.
REQ-033 Test: drive wb_en=1, wb_rd=1, wb_data=0xDEADBEEF while decoding add x2,x1,x1 -> rs1_data=rs2_data=0xDEADBEEF in the same cycle; after the edge the register still reads 0xDEADBEEF.
REQ-034 Test: drive wb_en=1, wb_rd=0, wb_data=0x1234, then read x0 -> rs1_data=0.
REQ-035 Test: decode beq with imm=-8 (0xFE000CE3) -> imm=0xFFFFFFF8, branch=1, reg_write=0; decode jal x1,+2048 -> imm=0x00000800, jump=1.
REQ-036 Test: assert stall for 2 cycles with a new instruction_in -> outputs unchanged; assert stall and flush together -> next cycle valid_out=0 and all controls 0.
REQ-037 Test: present opcode 0x7F, then SUB with funct7=0x20 and funct3=001 -> illegal=1 with all side-effect controls 0.
